// File: rtl/jtag_dr_pkg.sv
// Shared types and helpers for the JTAG data-register bank: TAP state
// encodings, the 1149.1 next-state function and the fixed opcodes.
package jtag_dr_pkg;

  localparam int IDCODE_WIDTH = 32;

  typedef enum logic [3:0] {
    TAP_EXIT2_DR = 4'h0,
    TAP_EXIT1_DR = 4'h1,
    TAP_SHIFT_DR = 4'h2,
    TAP_PAUSE_DR = 4'h3,
    TAP_SEL_IR   = 4'h4,
    TAP_UPD_DR   = 4'h5,
    TAP_CAP_DR   = 4'h6,
    TAP_SEL_DR   = 4'h7,
    TAP_EXIT2_IR = 4'h8,
    TAP_EXIT1_IR = 4'h9,
    TAP_SHIFT_IR = 4'hA,
    TAP_PAUSE_IR = 4'hB,
    TAP_RTI      = 4'hC,
    TAP_UPD_IR   = 4'hD,
    TAP_CAP_IR   = 4'hE,
    TAP_TLR      = 4'hF
  } tap_state_e;

  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    tap_state_e n;
    n = TAP_TLR;
    case (s)
      TAP_TLR:      n = tms ? TAP_TLR      : TAP_RTI;
      TAP_RTI:      n = tms ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_DR:   n = tms ? TAP_SEL_IR   : TAP_CAP_DR;
      TAP_CAP_DR:   n = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_SHIFT_DR: n = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_EXIT1_DR: n = tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
      TAP_PAUSE_DR: n = tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
      TAP_EXIT2_DR: n = tms ? TAP_UPD_DR   : TAP_SHIFT_DR;
      TAP_UPD_DR:   n = tms ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_IR:   n = tms ? TAP_TLR      : TAP_CAP_IR;
      TAP_CAP_IR:   n = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_SHIFT_IR: n = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_EXIT1_IR: n = tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
      TAP_PAUSE_IR: n = tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
      TAP_EXIT2_IR: n = tms ? TAP_UPD_IR   : TAP_SHIFT_IR;
      TAP_UPD_IR:   n = tms ? TAP_SEL_DR   : TAP_RTI;
      default:      n = TAP_TLR;
    endcase
    return n;
  endfunction

  function automatic int unsigned bypass_opcode(input int unsigned ir_width);
    return (32'd1 << ir_width) - 32'd1;
  endfunction

  function automatic int unsigned idcode_opcode(input int unsigned ir_width);
    return bypass_opcode(ir_width) - 32'd1;
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// Oversamples the JTAG pins on clk_i, derives TCK edge pulses and runs the
// TAP controller state register.
module jtag_tap_fsm
  import jtag_dr_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tck_i,
  input  logic       tms_i,
  input  logic       td_i,
  output logic       tck_rise,
  output logic       tck_fall,
  output logic       tms_sync,
  output logic       tdi_sync,
  output tap_state_e state
);

  logic [2:0] tck_sync;
  logic [1:0] tms_meta;
  logic [1:0] tdi_meta;
  tap_state_e state_q;
  tap_state_e state_d;

  // Third TCK stage exists only to compare against the second for edges.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tck_sync <= '0;
      tms_meta <= '0;
      tdi_meta <= '0;
      tck_rise <= 1'b0;
      tck_fall <= 1'b0;
    end else begin
      tck_sync <= {tck_sync[1:0], tck_i};
      tms_meta <= {tms_meta[0], tms_i};
      tdi_meta <= {tdi_meta[0], td_i};
      tck_rise <= tck_sync[1] & ~tck_sync[2];
      tck_fall <= ~tck_sync[1] & tck_sync[2];
    end
  end

  assign tms_sync = tms_meta[1];
  assign tdi_sync = tdi_meta[1];

  // NOTE: assign a default first so no path through the block infers a latch.
  always_comb begin
    state_d = state_q;
    if (tck_rise) state_d = tap_next(state_q, tms_sync);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= TAP_TLR;
    else       state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/jtag_dr_bank.sv
// JTAG front end with an instruction register, IDCODE, BYPASS and NUM_REGS
// uniform user data registers, all clocked on the system clock.
module jtag_dr_bank
  import jtag_dr_pkg::*;
#(
  parameter int          NUM_REGS   = 4,
  parameter int          REG_WIDTH  = 32,
  parameter int          IR_WIDTH   = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          tck_i,
  input  logic                          tms_i,
  input  logic                          td_i,
  output logic                          td_o,
  output logic                          td_oe_o,
  input  logic [NUM_REGS*REG_WIDTH-1:0] reg_capture_i,
  output logic [NUM_REGS*REG_WIDTH-1:0] reg_update_o,
  output logic [NUM_REGS-1:0]           reg_update_valid_o,
  output logic [3:0]                    tap_state_o,
  output logic [IR_WIDTH-1:0]           ir_o
);

  localparam int DR_WIDTH = (REG_WIDTH > IDCODE_WIDTH) ? REG_WIDTH : IDCODE_WIDTH;
  localparam logic [IR_WIDTH-1:0] IDCODE_OP = IR_WIDTH'(idcode_opcode(IR_WIDTH));

  logic          tck_rise;
  logic          tck_fall;
  logic          tms_sync;
  logic          tdi_sync;
  tap_state_e    state;
  tap_state_e    state_next;

  logic [IR_WIDTH-1:0] ir_sr;
  logic [IR_WIDTH-1:0] ir_q;
  logic [DR_WIDTH-1:0] dr_sr;
  logic [DR_WIDTH-1:0] dr_capture;
  logic [DR_WIDTH-1:0] dr_shifted;
  logic [NUM_REGS-1:0] sel_onehot;
  logic                sel_user;
  logic                sel_idcode;

  jtag_tap_fsm u_tap (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .tck_i    (tck_i),
    .tms_i    (tms_i),
    .td_i     (td_i),
    .tck_rise (tck_rise),
    .tck_fall (tck_fall),
    .tms_sync (tms_sync),
    .tdi_sync (tdi_sync),
    .state    (state)
  );

  // Update actions fire on the tck_rise that enters the Update states, so
  // the pulse lines up with the cycle tap_state_o first shows Update-DR.
  assign state_next = tap_next(state, tms_sync);

  // Unlisted opcodes fall through to the 1-bit bypass path.
  always_comb begin
    sel_onehot = '0;
    dr_capture = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (ir_q == IR_WIDTH'(k)) begin
        sel_onehot[k]              = 1'b1;
        dr_capture[REG_WIDTH-1:0]  = reg_capture_i[k*REG_WIDTH +: REG_WIDTH];
      end
    end
    sel_user   = |sel_onehot;
    sel_idcode = (ir_q == IDCODE_OP);
    if (sel_idcode) dr_capture[IDCODE_WIDTH-1:0] = IDCODE_VAL;

    dr_shifted = dr_sr >> 1;
    if (sel_user)        dr_shifted[REG_WIDTH-1]    = tdi_sync;
    else if (sel_idcode) dr_shifted[IDCODE_WIDTH-1] = tdi_sync;
    else                 dr_shifted = {{(DR_WIDTH-1){1'b0}}, tdi_sync};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ir_sr <= '0;
      ir_q  <= IDCODE_OP;
    end else begin
      if (tck_rise) begin
        if (state == TAP_CAP_IR)   ir_sr <= IR_WIDTH'(1);
        if (state == TAP_SHIFT_IR) ir_sr <= {tdi_sync, ir_sr[IR_WIDTH-1:1]};
        if (state_next == TAP_UPD_IR) ir_q <= ir_sr;
      end
      if (state == TAP_TLR) ir_q <= IDCODE_OP;
    end
  end

  // reg_update_o survives Test-Logic-Reset; only rst_i clears it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dr_sr              <= '0;
      reg_update_o       <= '0;
      reg_update_valid_o <= '0;
    end else begin
      reg_update_valid_o <= '0;
      if (tck_rise) begin
        if (state == TAP_CAP_DR)   dr_sr <= dr_capture;
        if (state == TAP_SHIFT_DR) dr_sr <= dr_shifted;
        if (state_next == TAP_UPD_DR) begin
          for (int k = 0; k < NUM_REGS; k++) begin
            if (sel_onehot[k]) begin
              reg_update_o[k*REG_WIDTH +: REG_WIDTH] <= dr_sr[REG_WIDTH-1:0];
              reg_update_valid_o[k]                  <= 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      td_o    <= 1'b0;
      td_oe_o <= 1'b0;
    end else if (tck_fall) begin
      case (state)
        TAP_SHIFT_IR: begin
          td_o    <= ir_sr[0];
          td_oe_o <= 1'b1;
        end
        TAP_SHIFT_DR: begin
          td_o    <= dr_sr[0];
          td_oe_o <= 1'b1;
        end
        default: begin
          td_o    <= 1'b0;
          td_oe_o <= 1'b0;
        end
      endcase
    end
  end

  assign tap_state_o = state;
  assign ir_o        = ir_q;

endmodule

// File: tb/tb_jtag_dr_bank.sv
// Self-checking bench for jtag_dr_bank: drives TCK/TMS/TDI scans and checks
// TDO words through a scoreboard queue plus register and pulse side effects.
module tb_jtag_dr_bank;

  localparam int NR  = 4;
  localparam int RW  = 32;
  localparam int IRW = 4;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              tck_i = 1'b0;
  logic              tms_i = 1'b1;
  logic              td_i  = 1'b0;
  logic              td_o;
  logic              td_oe_o;
  logic [NR*RW-1:0]  reg_capture_i = '0;
  logic [NR*RW-1:0]  reg_update_o;
  logic [NR-1:0]     reg_update_valid_o;
  logic [3:0]        tap_state_o;
  logic [IRW-1:0]    ir_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic        tdo_s;
  logic        oe_s;
  logic [31:0] exp_q[$];
  logic [31:0] got;
  logic [31:0] exp_w;

  int          pulse_cycles = 0;
  logic [NR-1:0] last_valid = '0;
  logic [3:0]  pulse_state  = '0;

  jtag_dr_bank #(
    .NUM_REGS  (NR),
    .REG_WIDTH (RW),
    .IR_WIDTH  (IRW),
    .IDCODE_VAL(32'h1000_0001)
  ) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .tck_i              (tck_i),
    .tms_i              (tms_i),
    .td_i               (td_i),
    .td_o               (td_o),
    .td_oe_o            (td_oe_o),
    .reg_capture_i      (reg_capture_i),
    .reg_update_o       (reg_update_o),
    .reg_update_valid_o (reg_update_valid_o),
    .tap_state_o        (tap_state_o),
    .ir_o               (ir_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (reg_update_valid_o != '0) begin
      pulse_cycles = pulse_cycles + 1;
      last_valid   = reg_update_valid_o;
      pulse_state  = tap_state_o;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // One full TCK period; TDO is sampled after the falling edge has settled.
  task automatic tck(input logic tms, input logic tdi);
    @(negedge clk_i);
    tms_i = tms;
    td_i  = tdi;
    repeat (4) @(negedge clk_i);
    tck_i = 1'b1;
    repeat (8) @(negedge clk_i);
    tck_i = 1'b0;
    repeat (8) @(negedge clk_i);
    tdo_s = td_o;
    oe_s  = td_oe_o;
  endtask

  task automatic to_shift_dr();
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    tck(1'b0, 1'b0);
  endtask

  task automatic to_shift_ir();
    tck(1'b1, 1'b0);
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    tck(1'b0, 1'b0);
  endtask

  // Shifts n bits LSB-first, leaving the TAP in Exit1; dout collects TDO.
  task automatic shift_bits(input int n, input logic [31:0] din, output logic [31:0] dout);
    dout    = '0;
    dout[0] = tdo_s;
    for (int i = 0; i < n; i++) begin
      tck(i == n - 1, din[i]);
      if (i < n - 1) dout[i+1] = tdo_s;
    end
  endtask

  task automatic finish_update();
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
  endtask

  task automatic load_ir(input logic [IRW-1:0] op);
    logic [31:0] out;
    to_shift_ir();
    exp_q.push_back(32'h0000_0001);
    shift_bits(IRW, 32'(op), out);
    finish_update();
    exp_w = exp_q.pop_front();
    n_checks++;
    if (out !== exp_w) begin
      n_fail++;
      $display("FAIL ir_capture: got %h expected %h", out, exp_w);
    end
    n_checks++;
    if (ir_o !== op) begin
      n_fail++;
      $display("FAIL ir_load: got %h expected %h", ir_o, op);
    end
  endtask

  task automatic write_reg(input logic [31:0] din, input logic [31:0] exp_read);
    to_shift_dr();
    exp_q.push_back(exp_read);
    shift_bits(32, din, got);
    finish_update();
    exp_w = exp_q.pop_front();
    n_checks++;
    if (got !== exp_w) begin
      n_fail++;
      $display("FAIL dr_read: got %h expected %h", got, exp_w);
    end
  endtask

  task automatic test_reset();
    repeat (4) @(negedge clk_i);
    rst_i = 1'b0;
    n_checks++;
    if (tap_state_o !== 4'hF) begin n_fail++; $display("FAIL reset_state: got %h expected %h", tap_state_o, 4'hF); end
    n_checks++;
    if (ir_o !== 4'hE) begin n_fail++; $display("FAIL reset_ir: got %h expected %h", ir_o, 4'hE); end
    n_checks++;
    if ({td_o, td_oe_o} !== 2'b00) begin n_fail++; $display("FAIL reset_tdo: got %b expected 00", {td_o, td_oe_o}); end
    n_checks++;
    if (reg_update_o !== '0) begin n_fail++; $display("FAIL reset_update: got %h expected 0", reg_update_o); end
    n_checks++;
    if (reg_update_valid_o !== '0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", reg_update_valid_o); end
    tck(1'b0, 1'b0);
    n_checks++;
    if (tap_state_o !== 4'hC) begin n_fail++; $display("FAIL reset_to_rti: got %h expected %h", tap_state_o, 4'hC); end
  endtask

  task automatic test_idcode();
    int c0;
    c0 = pulse_cycles;
    to_shift_dr();
    n_checks++;
    if (oe_s !== 1'b1) begin n_fail++; $display("FAIL idcode_oe: got %b expected 1", oe_s); end
    exp_q.push_back(32'h1000_0001);
    shift_bits(32, 32'h0, got);
    n_checks++;
    if (oe_s !== 1'b0) begin n_fail++; $display("FAIL idcode_oe_exit: got %b expected 0", oe_s); end
    finish_update();
    exp_w = exp_q.pop_front();
    n_checks++;
    if (got !== exp_w) begin n_fail++; $display("FAIL idcode_read: got %h expected %h", got, exp_w); end
    n_checks++;
    if (ir_o !== 4'hE) begin n_fail++; $display("FAIL idcode_ir: got %h expected %h", ir_o, 4'hE); end
    n_checks++;
    if (pulse_cycles != c0) begin n_fail++; $display("FAIL idcode_no_pulse: got %0d expected %0d", pulse_cycles, c0); end
  endtask

  task automatic test_ir_load();
    logic [31:0] out;
    to_shift_ir();
    exp_q.push_back(32'h0000_0001);
    shift_bits(IRW, 32'h2, out);
    n_checks++;
    if (ir_o !== 4'hE) begin n_fail++; $display("FAIL ir_before_update: got %h expected %h", ir_o, 4'hE); end
    finish_update();
    exp_w = exp_q.pop_front();
    n_checks++;
    if (out[1:0] !== exp_w[1:0]) begin n_fail++; $display("FAIL ir_first_bits: got %b expected %b", out[1:0], exp_w[1:0]); end
    n_checks++;
    if (ir_o !== 4'h2) begin n_fail++; $display("FAIL ir_after_update: got %h expected %h", ir_o, 4'h2); end
  endtask

  task automatic test_write_reg2();
    int c0;
    reg_capture_i = {32'hC3C3_0003, 32'h1234_5678, 32'hC1C1_0001, 32'hC0C0_0000};
    c0 = pulse_cycles;
    write_reg(32'hDEAD_BEEF, 32'h1234_5678);
    n_checks++;
    if (reg_update_o !== {32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0}) begin
      n_fail++; $display("FAIL reg2_update: got %h expected %h", reg_update_o, {32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0});
    end
    n_checks++;
    if (pulse_cycles - c0 != 1) begin n_fail++; $display("FAIL reg2_pulse_len: got %0d expected 1", pulse_cycles - c0); end
    n_checks++;
    if (last_valid !== 4'b0100) begin n_fail++; $display("FAIL reg2_pulse_mask: got %b expected 0100", last_valid); end
    n_checks++;
    if (pulse_state !== 4'h5) begin n_fail++; $display("FAIL reg2_pulse_state: got %h expected 5", pulse_state); end
  endtask

  task automatic test_back_to_back();
    int c0;
    c0 = pulse_cycles;
    load_ir(4'h0);
    write_reg(32'h0BAD_F00D, 32'hC0C0_0000);
    write_reg(32'h1111_2222, 32'hC0C0_0000);
    load_ir(4'h3);
    write_reg(32'h3333_4444, 32'hC3C3_0003);
    n_checks++;
    if (reg_update_o !== {32'h3333_4444, 32'hDEAD_BEEF, 32'h0, 32'h1111_2222}) begin
      n_fail++; $display("FAIL b2b_update: got %h expected %h", reg_update_o, {32'h3333_4444, 32'hDEAD_BEEF, 32'h0, 32'h1111_2222});
    end
    n_checks++;
    if (pulse_cycles - c0 != 3) begin n_fail++; $display("FAIL b2b_pulses: got %0d expected 3", pulse_cycles - c0); end
    n_checks++;
    if (last_valid !== 4'b1000) begin n_fail++; $display("FAIL b2b_last_mask: got %b expected 1000", last_valid); end
  endtask

  task automatic test_bypass(input logic [IRW-1:0] op, input logic [31:0] din, input logic [31:0] expect_out);
    int c0;
    load_ir(op);
    c0 = pulse_cycles;
    to_shift_dr();
    exp_q.push_back(expect_out);
    shift_bits(4, din, got);
    finish_update();
    exp_w = exp_q.pop_front();
    n_checks++;
    if (got !== exp_w) begin n_fail++; $display("FAIL bypass_%h: got %h expected %h", op, got, exp_w); end
    n_checks++;
    if (pulse_cycles != c0) begin n_fail++; $display("FAIL bypass_no_pulse_%h: got %0d expected %0d", op, pulse_cycles, c0); end
  endtask

  task automatic test_tms_reset();
    logic [NR*RW-1:0] keep;
    int c0;
    load_ir(4'h1);
    write_reg(32'h5A5A_1234, 32'hC1C1_0001);
    keep = {32'h3333_4444, 32'hDEAD_BEEF, 32'h5A5A_1234, 32'h1111_2222};
    load_ir(4'hF);
    c0 = pulse_cycles;
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    tck(1'b0, 1'b0);
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    n_checks++;
    if (tap_state_o !== 4'h3) begin n_fail++; $display("FAIL pause_dr: got %h expected 3", tap_state_o); end
    for (int i = 0; i < 4; i++) tck(1'b1, 1'b0);
    n_checks++;
    if (tap_state_o !== 4'h4) begin n_fail++; $display("FAIL tms_four: got %h expected 4", tap_state_o); end
    tck(1'b1, 1'b0);
    n_checks++;
    if (tap_state_o !== 4'hF) begin n_fail++; $display("FAIL tms_five: got %h expected F", tap_state_o); end
    n_checks++;
    if (ir_o !== 4'hE) begin n_fail++; $display("FAIL tms_ir: got %h expected E", ir_o); end
    n_checks++;
    if (reg_update_o !== keep) begin n_fail++; $display("FAIL tms_retain: got %h expected %h", reg_update_o, keep); end
    n_checks++;
    if (pulse_cycles != c0) begin n_fail++; $display("FAIL tms_no_pulse: got %0d expected %0d", pulse_cycles, c0); end
    tck(1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_shift();
    int c0;
    load_ir(4'h2);
    c0 = pulse_cycles;
    to_shift_dr();
    for (int i = 0; i < 10; i++) tck(1'b0, i[0]);
    n_checks++;
    if (tap_state_o !== 4'h2) begin n_fail++; $display("FAIL mid_shift_state: got %h expected 2", tap_state_o); end
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    n_checks++;
    if (tap_state_o !== 4'hF) begin n_fail++; $display("FAIL mid_rst_state: got %h expected F", tap_state_o); end
    n_checks++;
    if (reg_update_o !== '0) begin n_fail++; $display("FAIL mid_rst_update: got %h expected 0", reg_update_o); end
    n_checks++;
    if (ir_o !== 4'hE) begin n_fail++; $display("FAIL mid_rst_ir: got %h expected E", ir_o); end
    n_checks++;
    if ({td_o, td_oe_o} !== 2'b00) begin n_fail++; $display("FAIL mid_rst_tdo: got %b expected 00", {td_o, td_oe_o}); end
    for (int i = 0; i < 3; i++) tck(1'b0, 1'b1);
    n_checks++;
    if (pulse_cycles != c0) begin n_fail++; $display("FAIL mid_rst_no_pulse: got %0d expected %0d", pulse_cycles, c0); end
    n_checks++;
    if (reg_update_o !== '0) begin n_fail++; $display("FAIL mid_rst_update_later: got %h expected 0", reg_update_o); end
  endtask

  initial begin
    test_reset();
    test_idcode();
    test_ir_load();
    test_write_reg2();
    test_back_to_back();
    test_bypass(4'hF, 32'h0000_000D, 32'h0000_000A);
    test_bypass(4'h7, 32'h0000_0006, 32'h0000_000C);
    test_tms_reset();
    test_reset_mid_shift();
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d expected 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
